// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and sizing helpers.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_steps(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-step operation still needs a 1-bit counter.
    function automatic int calc_cnt_w(input int steps);
        return (steps <= 2) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder built from full-adder cells.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    // Carry into the top cell is exported so the caller can form signed overflow.
    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: WIDTH/DIGIT digits processed per operation, LSB first.
// Latency: done pulses WIDTH/DIGIT cycles after the accepting edge.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int STEPS = calc_steps(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(STEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be 2..64 and an exact multiple of DIGIT");
    end

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             co_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DIGIT-1:0] dig_s;
    logic             dig_co;
    logic             dig_cmsb;
    logic             accept;
    logic             running;
    logic             last_step;

    assign running   = (state_q == RUN);
    assign accept    = start && !running;
    assign last_step = running && (cnt_q == LAST);

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (a_sr[DIGIT-1:0]),
        .b     (b_sr[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    // Result digits enter from the MSB side so the final shift lands them in place.
    if (STEPS == 1) begin : g_one_step
        assign res_nxt = dig_s;
    end else begin : g_multi_step
        assign res_nxt = {dig_s, res_sr[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1; ci is irrelevant in that mode.
            a_sr    <= a;
            b_sr    <= sub ? ~b : b;
            carry_q <= sub | ci;
            cnt_q   <= '0;
        end else if (running) begin
            a_sr    <= a_sr >> DIGIT;
            b_sr    <= b_sr >> DIGIT;
            res_sr  <= res_nxt;
            carry_q <= dig_co;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_step) begin
                sum_q <= res_nxt;
                co_q  <= dig_co;
                ovf_q <= dig_co ^ dig_cmsb;
            end
        end
    end

    assign sum = sum_q;
    assign co  = co_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder across several WIDTH/DIGIT configurations.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // 8-bit, 1 bit per cycle
    logic       start8 = 1'b0, ci8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, co8, ovf8;
    logic [7:0] sum8;

    // 16-bit, 4 bits per cycle
    logic        start16 = 1'b0, ci16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, co16, ovf16;
    logic [15:0] sum16;

    // 4-bit, shared stimulus for DIGIT=1 and DIGIT=2
    logic       start4 = 1'b0, ci4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4a, done4a, co4a, ovf4a;
    logic [3:0] sum4a;
    logic       busy4b, done4b, co4b, ovf4b;
    logic [3:0] sum4b;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .ci(ci8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .co(co8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .ci(ci16), .sub(sub16),
        .busy(busy16), .done(done16), .sum(sum16), .co(co16), .ovf(ovf16)
    );

    serial_adder #(.WIDTH(4), .DIGIT(1)) u_dut4a (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .ci(ci4), .sub(sub4),
        .busy(busy4a), .done(done4a), .sum(sum4a), .co(co4a), .ovf(ovf4a)
    );

    serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut4b (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .ci(ci4), .sub(sub4),
        .busy(busy4b), .done(done4b), .sum(sum4b), .co(co4b), .ovf(ovf4b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch8(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s);
        a8 = av; b8 = bv; ci8 = c; sub8 = s; start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    // Counts cycles from the accepting edge until done, with a bound; sel picks the DUT.
    task automatic wait_done(input int sel, output int lat, output int busy_n);
        logic d, bz;
        lat = 0;
        busy_n = 0;
        d  = (sel == 16) ? done16 : done8;
        bz = (sel == 16) ? busy16 : busy8;
        while (!d && lat < 40) begin
            if (bz) busy_n++;
            tick();
            lat++;
            d  = (sel == 16) ? done16 : done8;
            bz = (sel == 16) ? busy16 : busy8;
        end
    endtask

    initial begin
        int lat, busy_n, seen_done;
        logic [3:0] ea, eb, bb;
        logic [4:0] r;
        logic       cc, eovf;

        // Reset state
        #2;
        check("rst_busy8", busy8, 1'b0);
        check("rst_done8", done8, 1'b0);
        check("rst_sum8", sum8, 8'h00);
        check("rst_co_ovf8", {co8, ovf8}, 2'b00);
        check("rst_sum16", sum16, 16'h0000);
        tick();
        rst_n = 1'b1;

        // Signed overflow on add
        launch8(8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done(8, lat, busy_n);
        check("ovf_add_lat", lat, 8);
        check("ovf_add_busy", busy_n, 8);
        check("ovf_add_busy_at_done", busy8, 1'b0);
        check("ovf_add_sum", sum8, 8'h80);
        check("ovf_add_co_ovf", {co8, ovf8}, 2'b01);
        tick();
        check("done_one_cycle", done8, 1'b0);

        // Carry-in propagation through all ones
        launch8(8'hFF, 8'h00, 1'b1, 1'b0);
        wait_done(8, lat, busy_n);
        check("ci_wrap_sum", sum8, 8'h00);
        check("ci_wrap_co_ovf", {co8, ovf8}, 2'b10);
        tick();

        // Subtract with borrow; ci must be ignored
        launch8(8'h05, 8'h07, 1'b1, 1'b1);
        wait_done(8, lat, busy_n);
        check("sub_borrow_sum", sum8, 8'hFE);
        check("sub_borrow_co_ovf", {co8, ovf8}, 2'b00);
        tick();

        launch8(8'h80, 8'h01, 1'b0, 1'b1);
        wait_done(8, lat, busy_n);
        check("sub_ovf_sum", sum8, 8'h7F);
        check("sub_ovf_co_ovf", {co8, ovf8}, 2'b11);
        tick();

        // Start during RUN is ignored and input changes have no effect
        launch8(8'h01, 8'h02, 1'b0, 1'b0);
        tick(); tick(); tick();
        a8 = 8'h11; b8 = 8'h22; ci8 = 1'b1; sub8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done(8, lat, busy_n);
        check("ignore_lat", lat + 4, 8);
        check("ignore_sum", sum8, 8'h03);
        check("ignore_co_ovf", {co8, ovf8}, 2'b00);

        // Back-to-back: accept in the DONE cycle
        launch8(8'h10, 8'h20, 1'b0, 1'b0);
        tick(); tick();
        check("held_sum_during_run", sum8, 8'h03);
        wait_done(8, lat, busy_n);
        check("b2b_lat", lat + 2, 8);
        check("b2b_sum", sum8, 8'h30);
        tick();

        // Asynchronous reset mid-run
        launch8(8'h55, 8'h0A, 1'b0, 1'b0);
        tick(); tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy_done", {busy8, done8}, 2'b00);
        check("abort_sum", sum8, 8'h00);
        check("abort_co_ovf", {co8, ovf8}, 2'b00);
        tick();
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) seen_done++;
        end
        check("abort_no_done", seen_done, 0);
        launch8(8'h03, 8'h04, 1'b0, 1'b0);
        wait_done(8, lat, busy_n);
        check("after_abort_lat", lat, 8);
        check("after_abort_sum", sum8, 8'h07);
        tick();

        // 16-bit, 4 bits per cycle
        a16 = 16'hFFFF; b16 = 16'h0001; ci16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        wait_done(16, lat, busy_n);
        check("w16_lat", lat, 4);
        check("w16_sum", sum16, 16'h0000);
        check("w16_co_ovf", {co16, ovf16}, 2'b10);
        tick();
        a16 = 16'h1234; b16 = 16'h4321; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        wait_done(16, lat, busy_n);
        check("w16_sum2", sum16, 16'h5555);
        tick();

        // 4-bit exhaustive against a behavioural model, both digit sizes
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    for (int c = 0; c < 2; c++) begin
                        if (s == 1 && c == 1) continue;
                        ea = 4'(i);
                        eb = 4'(j);
                        cc = (s == 1) ? 1'b1 : c[0];
                        bb = (s == 1) ? ~eb : eb;
                        r = {1'b0, ea} + {1'b0, bb} + {4'b0000, cc};
                        eovf = (ea[3] == bb[3]) && (r[3] != ea[3]);
                        a4 = ea; b4 = eb; sub4 = s[0];
                        ci4 = (s == 1) ? eb[0] : c[0];
                        start4 = 1'b1;
                        tick();
                        start4 = 1'b0;
                        tick(); tick();
                        check("x4_d2", {done4b, co4b, eovf ? ovf4b : ovf4b, sum4b},
                              {1'b1, r[4], eovf, r[3:0]});
                        tick(); tick();
                        check("x4_d1", {done4a, co4a, ovf4a, sum4a}, {1'b1, r[4], eovf, r[3:0]});
                        check("x4_d2_held", {co4b, ovf4b, sum4b}, {r[4], eovf, r[3:0]});
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
